python_spi_responder: RTL and testbench

//  SPI responder implementing the PYTHON image-sensor register protocol (the target end of the

---
 rtl/python_spi_responder_if.sv | 26 ++
 rtl/python_spi_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_python_spi_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/python_spi_responder_if.sv
// SPI link between a PYTHON-style register master and the responder.
// The master modport drives the chip select, serial clock and MOSI. The slave
// modport drives MISO and the MISO output enable.
interface python_spi_responder_if;
    logic spi_ss_n;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_ss_n,
        output spi_sck,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_ss_n,
        input  spi_sck,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/python_spi_responder.sv
// python_spi_responder: SPI target for the PYTHON image-sensor register protocol.
// Frame: addr[8:0], W, data[15:0], MSB first. MOSI is sampled on SCK rise and
// MISO changes on SCK fall. The whole link is oversampled on clk.
// The responder backs a local register file with a host port and reports
// committed SPI writes on the evt_* port.
// Optional build macro RTCL_SPI_RESP_SYNC_EN: when it is defined, ss_n, sck and
// mosi go through 2-FF synchronisers (2 clk extra latency, SCK <= clk/8). When
// it is undefined, these inputs are assumed to be synchronous to clk.
module python_spi_responder #(
    parameter int              ADDR_BITS  = 9,
    parameter int              DATA_BITS  = 16,
    parameter int              REG_DEPTH  = 256,
    parameter logic [15:0]     INIT_VALUE = 16'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    python_spi_responder_if.slave spi,
    input  logic                  host_wr_en,
    input  logic [ADDR_BITS-1:0]  host_addr,
    input  logic [DATA_BITS-1:0]  host_wr_data,
    output logic [DATA_BITS-1:0]  host_rd_data,
    output logic                  evt_valid,
    output logic [ADDR_BITS-1:0]  evt_addr,
    output logic [DATA_BITS-1:0]  evt_data,
    output logic                  busy
);
    localparam int FRAME_BITS = ADDR_BITS + 1 + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int IDX_W      = $clog2(REG_DEPTH);

    localparam logic [CNT_W-1:0] CNT_ADDR_LAST  = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ADDR       = 3'd1;
    localparam logic [2:0] ST_WRITE_DATA = 3'd2;
    localparam logic [2:0] ST_READ_DATA  = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    logic ss_n_s;
    logic sck_s;
    logic mosi_s;

`ifdef RTCL_SPI_RESP_SYNC_EN
    logic [1:0] ss_sync_reg;
    logic [1:0] sck_sync_reg;
    logic [1:0] mosi_sync_reg;

    // Two-stage synchronisers. ss_n resets low, so a select that is already
    // low never looks like a fresh falling edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync_reg   <= 2'b00;
            sck_sync_reg  <= 2'b00;
            mosi_sync_reg <= 2'b00;
        end else begin
            ss_sync_reg   <= {ss_sync_reg[0], spi.spi_ss_n};
            sck_sync_reg  <= {sck_sync_reg[0], spi.spi_sck};
            mosi_sync_reg <= {mosi_sync_reg[0], spi.spi_mosi};
        end
    end

    assign ss_n_s = ss_sync_reg[1];
    assign sck_s  = sck_sync_reg[1];
    assign mosi_s = mosi_sync_reg[1];
`else
    assign ss_n_s = spi.spi_ss_n;
    assign sck_s  = spi.spi_sck;
    assign mosi_s = spi.spi_mosi;
`endif

    logic [2:0]           state_reg;
    logic [2:0]           state_next;
    logic                 ss_prev_reg;
    logic                 sck_prev_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    // Only the trailing DATA_BITS frame bits are needed at once. The address
    // and W bit are taken out when rise #10 completes.
    logic [DATA_BITS-2:0] shift_reg;
    logic [DATA_BITS-1:0] shift_in;
    logic [ADDR_BITS-1:0] addr_reg;
    logic                 rd_req_reg;
    logic [DATA_BITS-1:0] rd_buf_reg;
    logic [DATA_BITS-1:0] rd_shift_reg;
    logic                 miso_reg;
    logic                 miso_oe_reg;
    logic                 commit_pending_reg;
    logic [DATA_BITS-1:0] commit_data_reg;
    logic                 evt_valid_reg;
    logic [ADDR_BITS-1:0] evt_addr_reg;
    logic [DATA_BITS-1:0] evt_data_reg;
    logic [DATA_BITS-1:0] host_rd_data_reg;
    logic [DATA_BITS-1:0] mem [0:REG_DEPTH-1];

    logic sck_rise;
    logic sck_fall;
    logic ss_fall;
    logic shifting;
    logic host_mapped;
    logic frame_mapped;

    assign sck_rise     = sck_s & ~sck_prev_reg;
    assign sck_fall     = ~sck_s & sck_prev_reg;
    // ss_prev_reg resets low, so a select that is held low through reset is
    // ignored until it goes high again.
    assign ss_fall      = ~ss_n_s & ss_prev_reg;
    assign shifting     = (state_reg == ST_ADDR) || (state_reg == ST_WRITE_DATA) ||
                          (state_reg == ST_READ_DATA);
    assign shift_in     = {shift_reg, mosi_s};
    assign host_mapped  = 32'(host_addr) < REG_DEPTH;
    assign frame_mapped = 32'(addr_reg) < REG_DEPTH;

    // Frame state machine. A high select always returns the FSM to idle, which
    // also covers an aborted frame.
    always_comb begin
        state_next = state_reg;
        if (ss_n_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:       if (ss_fall) state_next = ST_ADDR;
                ST_ADDR:       if (sck_rise && bit_cnt_reg == CNT_ADDR_LAST)
                                   state_next = shift_in[0] ? ST_WRITE_DATA : ST_READ_DATA;
                ST_WRITE_DATA,
                ST_READ_DATA:  if (sck_rise && bit_cnt_reg == CNT_FRAME_LAST)
                                   state_next = ST_DONE;
                ST_DONE:       state_next = ST_DONE;
                default:       state_next = ST_IDLE;
            endcase
        end
    end

    // Bit shifting, address capture, write commit request and MISO drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            ss_prev_reg        <= 1'b0;
            sck_prev_reg       <= 1'b0;
            bit_cnt_reg        <= '0;
            shift_reg          <= '0;
            addr_reg           <= '0;
            rd_req_reg         <= 1'b0;
            rd_shift_reg       <= '0;
            miso_reg           <= 1'b0;
            miso_oe_reg        <= 1'b0;
            commit_pending_reg <= 1'b0;
            commit_data_reg    <= '0;
        end else begin
            state_reg          <= state_next;
            ss_prev_reg        <= ss_n_s;
            sck_prev_reg       <= sck_s;
            rd_req_reg         <= 1'b0;
            commit_pending_reg <= 1'b0;
            if (ss_n_s) begin
                bit_cnt_reg <= '0;
                miso_reg    <= 1'b0;
                miso_oe_reg <= 1'b0;
            end else begin
                if (sck_rise && shifting) begin
                    shift_reg   <= shift_in[DATA_BITS-2:0];
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    if (state_reg == ST_ADDR && bit_cnt_reg == CNT_ADDR_LAST) begin
                        addr_reg   <= shift_in[ADDR_BITS:1];
                        rd_req_reg <= ~shift_in[0];
                    end
                    if (state_reg == ST_WRITE_DATA && bit_cnt_reg == CNT_FRAME_LAST) begin
                        commit_pending_reg <= 1'b1;
                        commit_data_reg    <= shift_in;
                    end
                end
                if (sck_fall) begin
                    if (state_reg == ST_READ_DATA) begin
                        miso_oe_reg <= 1'b1;
                        if (!miso_oe_reg) begin
                            miso_reg     <= rd_buf_reg[DATA_BITS-1];
                            rd_shift_reg <= {rd_buf_reg[DATA_BITS-2:0], 1'b0};
                        end else begin
                            miso_reg     <= rd_shift_reg[DATA_BITS-1];
                            rd_shift_reg <= {rd_shift_reg[DATA_BITS-2:0], 1'b0};
                        end
                    end else begin
                        miso_reg    <= 1'b0;
                        miso_oe_reg <= 1'b0;
                    end
                end
            end
        end
    end

    // Register file. The SPI commit is written last, so it wins over a host
    // write to the same address in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem[i] <= INIT_VALUE;
            end
        end else begin
            if (host_wr_en && host_mapped) begin
                mem[host_addr[IDX_W-1:0]] <= host_wr_data;
            end
            if (commit_pending_reg && frame_mapped) begin
                mem[addr_reg[IDX_W-1:0]] <= commit_data_reg;
            end
        end
    end

    // Registered read ports. The read buffer is frozen once latched, so later
    // host writes do not change the word that is already being shifted out.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_rd_data_reg <= '0;
            rd_buf_reg       <= '0;
        end else begin
            host_rd_data_reg <= host_mapped ? mem[host_addr[IDX_W-1:0]] : '0;
            if (rd_req_reg) begin
                rd_buf_reg <= frame_mapped ? mem[addr_reg[IDX_W-1:0]] : '0;
            end
        end
    end

    // Write-event pulse. It is only raised for writes that reach a mapped register.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid_reg <= 1'b0;
            evt_addr_reg  <= '0;
            evt_data_reg  <= '0;
        end else begin
            evt_valid_reg <= commit_pending_reg && frame_mapped;
            if (commit_pending_reg && frame_mapped) begin
                evt_addr_reg <= addr_reg;
                evt_data_reg <= commit_data_reg;
            end
        end
    end

    assign spi.spi_miso    = miso_reg;
    assign spi.spi_miso_oe = miso_oe_reg;
    assign host_rd_data    = host_rd_data_reg;
    assign evt_valid       = evt_valid_reg;
    assign evt_addr        = evt_addr_reg;
    assign evt_data        = evt_data_reg;
    assign busy            = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_python_spi_responder.sv
// Directed bench for python_spi_responder. It drives SCK at clk/8 and checks
// SPI writes, SPI reads, aborted frames, unmapped addresses, over-long frames
// and reset in the middle of a read.
module tb_python_spi_responder;
    logic        clk;
    logic        reset;
    logic        host_wr_en;
    logic [8:0]  host_addr;
    logic [15:0] host_wr_data;
    logic [15:0] host_rd_data;
    logic        evt_valid;
    logic [8:0]  evt_addr;
    logic [15:0] evt_data;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor counters. Only the monitor writes them; the stimulus reads deltas.
    int          evt_cycles = 0;
    int          oe_cycles  = 0;
    logic [8:0]  last_evt_addr = '0;
    logic [15:0] last_evt_data = '0;

    python_spi_responder_if spi_bus ();

    python_spi_responder dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi_bus.slave),
        .host_wr_en   (host_wr_en),
        .host_addr    (host_addr),
        .host_wr_data (host_wr_data),
        .host_rd_data (host_rd_data),
        .evt_valid    (evt_valid),
        .evt_addr     (evt_addr),
        .evt_data     (evt_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count event cycles and MISO-enable cycles at mid-period.
    always @(negedge clk) begin
        if (evt_valid === 1'b1) begin
            evt_cycles    = evt_cycles + 1;
            last_evt_addr = evt_addr;
            last_evt_data = evt_data;
        end
        if (spi_bus.spi_miso_oe === 1'b1) oe_cycles = oe_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One SCK period: MOSI set and MISO sampled in the low half, then the high half.
    task automatic spi_bit(input logic b, output logic m);
        spi_bus.spi_mosi = b;
        repeat (4) @(negedge clk);
        m = spi_bus.spi_miso;
        spi_bus.spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        spi_bus.spi_sck = 1'b0;
    endtask

    // Full frame of nbits SCKs. Bits beyond 26 are zero. The task optionally
    // writes to the host port at bit poke_bit.
    task automatic spi_xfer(input logic [8:0] a, input logic w, input logic [15:0] d,
                            input int nbits, input int poke_bit, input logic [8:0] poke_addr,
                            input logic [15:0] poke_data,
                            output logic [15:0] rd, output logic busy_mid);
        logic [25:0] fr;
        logic        b;
        logic        m;
        fr = {a, w, d};
        rd = '0;
        busy_mid = 1'b0;
        spi_bus.spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            b = (k < 26) ? fr[25 - k] : 1'b0;
            if (k == poke_bit) begin
                host_addr    = poke_addr;
                host_wr_data = poke_data;
                host_wr_en   = 1'b1;
                @(negedge clk);
                host_wr_en   = 1'b0;
            end
            spi_bit(b, m);
            if (k >= 10 && k < 26) rd[25 - k] = m;
            if (k == 5) busy_mid = busy;
        end
        repeat (4) @(negedge clk);
        spi_bus.spi_ss_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic host_write(input logic [8:0] a, input logic [15:0] d);
        host_addr    = a;
        host_wr_data = d;
        host_wr_en   = 1'b1;
        @(negedge clk);
        host_wr_en   = 1'b0;
    endtask

    task automatic host_read(input logic [8:0] a, output logic [15:0] d);
        host_addr = a;
        @(negedge clk);
        d = host_rd_data;
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] hd;
        logic        bm;
        logic        m;
        logic [25:0] fr;
        int          e0;
        int          o0;

        reset            = 1'b1;
        host_wr_en       = 1'b0;
        host_addr        = '0;
        host_wr_data     = '0;
        spi_bus.spi_ss_n = 1'b1;
        spi_bus.spi_sck  = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_miso_oe", 32'(spi_bus.spi_miso_oe), 32'd0);
        check("rst_miso", 32'(spi_bus.spi_miso), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_addr", 32'(evt_addr), 32'd0);
        check("rst_evt_data", 32'(evt_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_host_rd", 32'(host_rd_data), 32'd0);

        // Case 1: SPI write 0x005 = 0xA55A.
        e0 = evt_cycles;
        spi_xfer(9'h005, 1'b1, 16'hA55A, 26, -1, '0, '0, rd, bm);
        check("t1_busy_mid", 32'(bm), 32'd1);
        check("t1_evt_cycles", 32'(evt_cycles - e0), 32'd1);
        check("t1_evt_addr", 32'(last_evt_addr), 32'h005);
        check("t1_evt_data", 32'(last_evt_data), 32'hA55A);
        check("t1_busy_after", 32'(busy), 32'd0);
        host_read(9'h005, hd);
        check("t1_host_rd", 32'(hd), 32'hA55A);

        // Case 2: host writes 0x010 = 0x1234, then an SPI read shifts it out.
        host_write(9'h010, 16'h1234);
        e0 = evt_cycles;
        o0 = oe_cycles;
        spi_xfer(9'h010, 1'b0, 16'h0000, 26, -1, '0, '0, rd, bm);
        check("t2_rd_data", 32'(rd), 32'h1234);
        check("t2_oe_cycles", 32'(oe_cycles - o0), 32'd128);
        check("t2_no_evt", 32'(evt_cycles - e0), 32'd0);
        check("t2_oe_after", 32'(spi_bus.spi_miso_oe), 32'd0);

        // Case 2b: a host write during an in-flight read does not change the read data.
        spi_xfer(9'h005, 1'b0, 16'h0000, 26, 15, 9'h005, 16'h1111, rd, bm);
        check("t2b_rd_data", 32'(rd), 32'hA55A);
        host_read(9'h005, hd);
        check("t2b_host_rd", 32'(hd), 32'h1111);

        // Case 3: a write to 0x0FF is aborted after 20 bits.
        e0 = evt_cycles;
        spi_xfer(9'h0FF, 1'b1, 16'h5A5A, 20, -1, '0, '0, rd, bm);
        check("t3_no_evt", 32'(evt_cycles - e0), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        host_read(9'h0FF, hd);
        check("t3_reg_unchanged", 32'(hd), 32'h0000);

        // Case 4: address 0x1FF is unmapped.
        e0 = evt_cycles;
        spi_xfer(9'h1FF, 1'b1, 16'hFFFF, 26, -1, '0, '0, rd, bm);
        check("t4_no_evt", 32'(evt_cycles - e0), 32'd0);
        o0 = oe_cycles;
        spi_xfer(9'h1FF, 1'b0, 16'h0000, 26, -1, '0, '0, rd, bm);
        check("t4_rd_zero", 32'(rd), 32'h0000);
        check("t4_oe_cycles", 32'(oe_cycles - o0), 32'd128);
        host_read(9'h1FF, hd);
        check("t4_host_rd_zero", 32'(hd), 32'h0000);

        // Case 5: a 30-SCK frame writes 0x020 = 0xBEEF; the extra bits are ignored.
        e0 = evt_cycles;
        spi_xfer(9'h020, 1'b1, 16'hBEEF, 30, -1, '0, '0, rd, bm);
        check("t5_evt_cycles", 32'(evt_cycles - e0), 32'd1);
        check("t5_evt_addr", 32'(last_evt_addr), 32'h020);
        check("t5_evt_data", 32'(last_evt_data), 32'hBEEF);
        host_read(9'h020, hd);
        check("t5_host_rd", 32'(hd), 32'hBEEF);

        // Case 6: reset is asserted in the middle of a read of 0x010.
        fr = {9'h010, 1'b0, 16'h0000};
        spi_bus.spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 14; k++) spi_bit(fr[25 - k], m);
        @(negedge clk);
        check("t6_oe_before_rst", 32'(spi_bus.spi_miso_oe), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_oe_after_rst", 32'(spi_bus.spi_miso_oe), 32'd0);
        reset = 1'b0;
        check("t6_busy_after_rst", 32'(busy), 32'd0);
        e0 = evt_cycles;
        o0 = oe_cycles;
        for (int k = 14; k < 26; k++) spi_bit(fr[25 - k], m);
        check("t6_ignored_busy", 32'(busy), 32'd0);
        check("t6_ignored_oe", 32'(oe_cycles - o0), 32'd0);
        check("t6_ignored_evt", 32'(evt_cycles - e0), 32'd0);
        repeat (4) @(negedge clk);
        spi_bus.spi_ss_n = 1'b1;
        repeat (6) @(negedge clk);
        host_read(9'h010, hd);
        check("t6_reg010_init", 32'(hd), 32'h0000);
        host_read(9'h020, hd);
        check("t6_reg020_init", 32'(hd), 32'h0000);
        e0 = evt_cycles;
        spi_xfer(9'h030, 1'b1, 16'hCAFE, 26, -1, '0, '0, rd, bm);
        check("t6_next_evt", 32'(evt_cycles - e0), 32'd1);
        check("t6_next_evt_data", 32'(last_evt_data), 32'hCAFE);
        spi_xfer(9'h030, 1'b0, 16'h0000, 26, -1, '0, '0, rd, bm);
        check("t6_next_rd", 32'(rd), 32'hCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
